// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding, oversample default
// and the line levels of the start and stop bits.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int STATE_W        = 3;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input; reset value is
// selectable so idle-high lines come out of reset in their idle state.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// UART 8N1 receiver on a 16x oversample tick: finds the start bit, samples each
// bit at its centre and hands bytes to the next stage over valid/ready.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rxclk_en,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int               CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver;
    logic                 frame_bad;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .d_i     (i_rx),
        .q_o     (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
        end
    end

    // Everything advances only on oversample ticks; without ticks the FSM freezes.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        deliver      = 1'b0;
        frame_bad    = 1'b0;
        if (i_rxclk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_s == START_BIT) begin
                        state_d      = ST_START;
                        sample_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (sample_cnt_q == MID_CNT) begin
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                        state_d      = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sample_cnt_q == LAST_CNT) begin
                        sample_cnt_d = '0;
                        shift_d      = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d    = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            state_d   = ST_STOP;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (sample_cnt_q == LAST_CNT) begin
                        sample_cnt_d = '0;
                        if (rx_s == STOP_BIT) begin
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            frame_bad = 1'b1;
                            state_d   = ST_WAIT_HI;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_HI: begin
                    // A held-low line (break) must go high before a new start is accepted.
                    if (rx_s == STOP_BIT) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Valid/ready: a byte is transferred on every cycle with o_valid & i_ready; o_data
    // is frozen while o_valid is high, and a delivery into a full, non-accepting
    // holding register is dropped and reported on o_overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;
            overrun_q   <= 1'b0;
            if (deliver) begin
                if (!valid_q || i_ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: serial frames on a tick-every-4-clocks line, checked
// cycle by cycle against a frame-level model of the receiver and holding register.
module tb_uart_rx_os16;

    localparam int CLK_HALF = 5;
    localparam int TICK_DIV = 4;
    localparam int OS       = 16;
    localparam int BIT_CLKS = TICK_DIV * OS;
    localparam int SYNC_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic       busy;

    uart_rx_os16 #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SYNC_LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rxclk_en  (tick),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (ferr),
        .o_overrun   (ovr),
        .o_busy      (busy)
    );

    always #CLK_HALF clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_ferr_seen = 0;
    int n_ovr_seen  = 0;
    logic ready_cmd  = 1'b1;
    logic rand_ready = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        bit         ok;
    } frame_ev_t;

    frame_ev_t  ev_q[$];
    logic [7:0] acc_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_q.size()) return {24'd0, acc_q[i]};
        return 32'hDEAD;
    endfunction

    // Posedge at which the stop bit of a frame whose start edge is driven at the
    // negedge before posedge n+1 is judged: first tick after the synchronizer
    // passes the edge, then half a bit plus 8 data bits plus the stop bit.
    function automatic int stop_edge(input int n);
        int seen;
        int t0;
        seen = n + 1 + SYNC_LAT;
        t0   = seen + (((1 - seen) % TICK_DIV) + TICK_DIV) % TICK_DIV;
        return t0 + (OS / 2 + OS * 9) * TICK_DIV;
    endfunction

    // Tick on every posedge p with p % 4 == 1; ready is applied just after the negedge.
    initial begin
        tick  = 1'b0;
        ready = 1'b0;
        forever begin
            @(negedge clk);
            tick = (cyc % TICK_DIV == 0);
            #1;
            ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
        end
    end

    // Model: each frame becomes an event at its stop-judgement edge; the holding
    // register accepts on valid&ready and drops a delivery when full and not ready.
    initial begin
        logic       m_valid;
        logic [7:0] m_data;
        logic       m_ferr;
        logic       m_ovr;
        logic       r;
        logic       rs;
        logic       full;
        logic       prev_valid;
        logic [7:0] prev_data;
        frame_ev_t  ev;
        m_valid    = 1'b0;
        m_data     = 8'd0;
        prev_valid = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(posedge clk);
            cyc++;
            r      = ready;
            rs     = rst_n;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (!rs) begin
                m_valid = 1'b0;
                m_data  = 8'd0;
            end else begin
                if (prev_valid && r) acc_q.push_back(prev_data);
                full = m_valid && !r;
                if (m_valid && r) m_valid = 1'b0;
                if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
                    ev = ev_q.pop_front();
                    if (!ev.ok) m_ferr = 1'b1;
                    else if (full) m_ovr = 1'b1;
                    else begin
                        m_data  = ev.d;
                        m_valid = 1'b1;
                    end
                end
            end
            #1;
            chk("o_valid", {31'd0, valid}, {31'd0, m_valid});
            chk("o_data", {24'd0, data}, {24'd0, m_data});
            chk("o_frame_err", {31'd0, ferr}, {31'd0, m_ferr});
            chk("o_overrun", {31'd0, ovr}, {31'd0, m_ovr});
            n_ferr_seen += int'(ferr);
            n_ovr_seen  += int'(ovr);
            prev_valid = valid;
            prev_data  = data;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        do @(negedge clk); while (cyc % TICK_DIV != 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit ok);
        frame_ev_t e;
        e.cyc = stop_edge(cyc);
        e.d   = d;
        e.ok  = ok;
        ev_q.push_back(e);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = ok;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, output int at, output logic [7:0] d_at);
        at   = -1;
        d_at = 8'hxx;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (valid) begin
                at   = cyc;
                d_at = data;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         n0;
        int         at;
        int         f0;
        int         o0;
        logic [7:0] d_at;
        logic [7:0] rd;
        bit         rok;
        rst_n = 1'b0;
        rx    = 1'b1;
        idle(5);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Nominal byte with latency pinned to a hand-computed value.
        acc_q.delete();
        f0 = n_ferr_seen;
        o0 = n_ovr_seen;
        align();
        n0 = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            wait_valid(1000, at, d_at);
        join
        chk("a5_latency", at - n0, 32'd613);
        chk("a5_data", {24'd0, d_at}, 32'hA5);
        idle(50);
        chk("a5_count", acc_q.size(), 32'd1);
        chk("a5_accepted", acc_at(0), 32'hA5);
        chk("a5_no_errors", n_ferr_seen - f0 + n_ovr_seen - o0, 32'd0);

        // Start-bit glitch of four ticks.
        acc_q.delete();
        align();
        rx = 1'b0;
        idle(12);
        chk("glitch_busy_mid", {31'd0, busy}, 32'd1);
        idle(4);
        rx = 1'b1;
        idle(200);
        chk("glitch_busy_end", {31'd0, busy}, 32'd0);
        chk("glitch_no_byte", acc_q.size(), 32'd0);

        // Bad stop bit, line held low, then a clean frame.
        acc_q.delete();
        f0 = n_ferr_seen;
        align();
        send_frame(8'h3C, 1'b0);
        idle(2 * BIT_CLKS);
        chk("break_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        idle(2 * BIT_CLKS);
        align();
        send_frame(8'h55, 1'b1);
        idle(100);
        chk("frame_err_count", n_ferr_seen - f0, 32'd1);
        chk("after_break_count", acc_q.size(), 32'd1);
        chk("after_break_byte", acc_at(0), 32'h55);

        // Overrun: two bytes with the consumer stalled.
        acc_q.delete();
        ready_cmd = 1'b0;
        o0 = n_ovr_seen;
        align();
        send_frame(8'h11, 1'b1);
        idle(64);
        align();
        send_frame(8'h22, 1'b1);
        idle(64);
        chk("ovr_hold_data", {24'd0, data}, 32'h11);
        chk("ovr_hold_valid", {31'd0, valid}, 32'd1);
        chk("ovr_pulses", n_ovr_seen - o0, 32'd1);
        ready_cmd = 1'b1;
        idle(3);
        ready_cmd = 1'b0;
        idle(3);
        chk("ovr_valid_drop", {31'd0, valid}, 32'd0);
        chk("ovr_accepted", acc_at(0), 32'h11);
        chk("ovr_count", acc_q.size(), 32'd1);

        // Accept of the held byte in the exact delivery cycle of the next one.
        acc_q.delete();
        o0 = n_ovr_seen;
        align();
        send_frame(8'h11, 1'b1);
        idle(64);
        align();
        n0 = cyc;
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (612) @(negedge clk);
                ready_cmd = 1'b1;
                @(negedge clk);
                ready_cmd = 1'b0;
            end
        join
        chk("coinc_data", {24'd0, data}, 32'h22);
        chk("coinc_valid", {31'd0, valid}, 32'd1);
        chk("coinc_no_ovr", n_ovr_seen - o0, 32'd0);
        chk("coinc_first", acc_at(0), 32'h11);
        ready_cmd = 1'b1;
        idle(3);
        chk("coinc_second", acc_at(1), 32'h22);
        chk("coinc_count", acc_q.size(), 32'd2);

        // Reset in the middle of the data bits of 0xFF.
        acc_q.delete();
        align();
        rx = 1'b0;
        idle(BIT_CLKS);
        rx = 1'b1;
        idle(4 * BIT_CLKS);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {30'd0, ferr, ovr}, 32'd0);
        idle(5);
        rst_n = 1'b1;
        idle(20);
        align();
        send_frame(8'h81, 1'b1);
        idle(100);
        chk("post_reset_count", acc_q.size(), 32'd1);
        chk("post_reset_byte", acc_at(0), 32'h81);

        // Random bytes, random stop errors, random phase and random consumer stalls.
        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rd  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 5) != 0);
            idle($urandom_range(1, 7));
            send_frame(rd, rok);
            if (!rok) begin
                idle($urandom_range(0, 2) * BIT_CLKS);
                rx = 1'b1;
            end
            idle(40);
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        idle(20);
        chk("final_idle", {31'd0, busy}, 32'd0);
        chk("events_consumed", ev_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
